// File: rtl/insn_decode_stage_pkg.sv
// Shared ISA definitions for the decode stage: instruction kinds, the decoded
// entry layout, field positions derived from the instruction width and fixed encodings.
package insn_decode_stage_pkg;

    localparam int INSN_WIDTH_DEF = 16;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int REG_WIDTH_DEF  = 4;
    localparam int FUNC_WIDTH_DEF = 5;
    localparam int NUM_FUNCS_DEF  = 18;

    localparam int FUNC_FIRST = 0;
    localparam int FUNC_LAST  = NUM_FUNCS_DEF - 1;

    localparam int HLT_INSN = 0;
    localparam int NOP_INSN = 1;

    typedef enum logic [2:0] {
        KIND_SET = 3'd0,
        KIND_BRJ = 3'd1,
        KIND_OP  = 3'd2,
        KIND_NOP = 3'd3,
        KIND_HLT = 3'd4,
        KIND_ILL = 3'd5
    } insn_kind_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } stage_state_t;

    typedef struct packed {
        insn_kind_t                kind;
        logic [REG_WIDTH_DEF-1:0]  reg_a;
        logic [REG_WIDTH_DEF-1:0]  reg_b;
        logic [FUNC_WIDTH_DEF-1:0] func;
        logic [DATA_WIDTH_DEF-1:0] immd;
        logic                      is_branch;
        logic                      relative;
        logic [DATA_WIDTH_DEF-1:0] pc;
    } decoded_insn_t;

    // Field positions, all measured from the top of a w-bit instruction word.
    function automatic int set_reg_lsb(input int w);  return w - 5;  endfunction
    function automatic int set_imm_w(input int w);    return w - 5;  endfunction
    function automatic int brj_imm_w(input int w);    return w - 4;  endfunction
    function automatic int op_reg_a_lsb(input int w); return w - 7;  endfunction
    function automatic int op_reg_b_lsb(input int w); return w - 11; endfunction

endpackage

// File: rtl/insn_decode_stage_if.sv
// Fetch-side and execute-side signals of the decode stage; master drives
// instructions and consumes entries, slave is the stage itself.
import insn_decode_stage_pkg::*;

interface insn_decode_stage_if #(
    parameter int INSN_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int REG_WIDTH  = 4,
    parameter int FUNC_WIDTH = 5
);
    // Handshake: a word moves on any rising edge where valid && ready; the
    // sender holds valid and data until then, and ready never depends on valid.
    logic                  in_valid;
    logic [INSN_WIDTH-1:0] in_insn;
    logic [DATA_WIDTH-1:0] in_pc;
    logic                  in_ready;
    logic                  flush;
    logic                  resume;
    logic                  out_valid;
    logic                  out_ready;
    insn_kind_t            out_kind;
    logic [REG_WIDTH-1:0]  out_reg_a;
    logic [REG_WIDTH-1:0]  out_reg_b;
    logic [FUNC_WIDTH-1:0] out_func;
    logic [DATA_WIDTH-1:0] out_immd;
    logic                  out_is_branch;
    logic                  out_relative;
    logic [DATA_WIDTH-1:0] out_pc;
    logic                  halted;

    modport master (
        output in_valid, in_insn, in_pc, flush, resume, out_ready,
        input  in_ready, out_valid, out_kind, out_reg_a, out_reg_b, out_func,
               out_immd, out_is_branch, out_relative, out_pc, halted
    );

    modport slave (
        input  in_valid, in_insn, in_pc, flush, resume, out_ready,
        output in_ready, out_valid, out_kind, out_reg_a, out_reg_b, out_func,
               out_immd, out_is_branch, out_relative, out_pc, halted
    );
endinterface

// File: rtl/insn_decode_stage_field_decoder.sv
// Combinational classification of one raw instruction word into a decoded entry;
// fields a kind does not use stay zero.
import insn_decode_stage_pkg::*;

module insn_field_decoder #(
    parameter int INSN_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int REG_WIDTH  = 4,
    parameter int FUNC_WIDTH = 5,
    parameter int NUM_FUNCS  = 18
) (
    input  logic [INSN_WIDTH-1:0] insn,
    input  logic [DATA_WIDTH-1:0] pc,
    output decoded_insn_t         dec
);
    localparam int SET_REG_LSB  = set_reg_lsb(INSN_WIDTH);
    localparam int SET_IMM_W    = set_imm_w(INSN_WIDTH);
    localparam int BRJ_IMM_W    = brj_imm_w(INSN_WIDTH);
    localparam int OP_REG_A_LSB = op_reg_a_lsb(INSN_WIDTH);
    localparam int OP_REG_B_LSB = op_reg_b_lsb(INSN_WIDTH);

    logic [2:0] cls;
    assign cls = insn[INSN_WIDTH-1 -: 3];

    always_comb begin
        dec    = '0;
        dec.pc = pc;
        if (cls[2]) begin
            dec.kind  = KIND_SET;
            dec.reg_a = insn[SET_REG_LSB +: REG_WIDTH];
            dec.immd  = {{(DATA_WIDTH-SET_IMM_W){1'b0}}, insn[SET_IMM_W-1:0]};
        end else if (cls[1]) begin
            dec.kind      = KIND_BRJ;
            dec.is_branch = insn[INSN_WIDTH-3];
            dec.relative  = insn[INSN_WIDTH-4];
            // Relative targets are signed offsets; absolute targets are plain addresses.
            if (insn[INSN_WIDTH-4])
                dec.immd = {{(DATA_WIDTH-BRJ_IMM_W){insn[BRJ_IMM_W-1]}}, insn[BRJ_IMM_W-1:0]};
            else
                dec.immd = {{(DATA_WIDTH-BRJ_IMM_W){1'b0}}, insn[BRJ_IMM_W-1:0]};
        end else if (cls[0]) begin
            if (int'(insn[FUNC_WIDTH-1:0]) < NUM_FUNCS) begin
                dec.kind  = KIND_OP;
                dec.reg_a = insn[OP_REG_A_LSB +: REG_WIDTH];
                dec.reg_b = insn[OP_REG_B_LSB +: REG_WIDTH];
                dec.func  = insn[FUNC_WIDTH-1:0];
            end else begin
                dec.kind = KIND_ILL;
            end
        end else if (insn == INSN_WIDTH'(HLT_INSN)) begin
            dec.kind = KIND_HLT;
        end else if (insn == INSN_WIDTH'(NOP_INSN)) begin
            dec.kind = KIND_NOP;
        end else begin
            dec.kind = KIND_ILL;
        end
    end
endmodule

// File: rtl/insn_decode_stage.sv
// Registered decode stage: field decoder at the input, output register plus one
// skid entry, and a RUN/HALTED FSM that stops acceptance after HLT.
import insn_decode_stage_pkg::*;

module insn_decode_stage #(
    parameter int INSN_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int REG_WIDTH  = 4,
    parameter int FUNC_WIDTH = 5,
    parameter int NUM_FUNCS  = 18
) (
    input logic                 clk,
    input logic                 rst_n,
    insn_decode_stage_if.slave  bus
);
    decoded_insn_t dec;
    decoded_insn_t out_q;
    decoded_insn_t skid_q;
    logic          out_valid_q;
    logic          skid_valid_q;
    logic          skid_valid_d;
    logic          in_ready_q;
    logic          accept;
    logic          out_free;
    stage_state_t  state_q;
    stage_state_t  state_d;

    insn_field_decoder #(
        .INSN_WIDTH (INSN_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .REG_WIDTH  (REG_WIDTH),
        .FUNC_WIDTH (FUNC_WIDTH),
        .NUM_FUNCS  (NUM_FUNCS)
    ) u_field_decoder (
        .insn (bus.in_insn),
        .pc   (bus.in_pc),
        .dec  (dec)
    );

    // A word arriving alongside a flush is dropped.
    assign accept   = bus.in_valid && in_ready_q && !bus.flush;
    assign out_free = !out_valid_q || bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (accept && dec.kind == KIND_HLT) state_d = ST_HALTED;
            ST_HALTED: if (bus.resume) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        bus.halted = (state_q == ST_HALTED);
    end

    always_comb begin
        skid_valid_d = skid_valid_q;
        if (bus.flush)    skid_valid_d = 1'b0;
        else if (out_free) skid_valid_d = skid_valid_q && accept;
        else              skid_valid_d = skid_valid_q || accept;
    end

    // in_ready is precomputed from next-cycle occupancy so out_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d && (state_d == ST_RUN);
            if (bus.flush) begin
                out_valid_q <= 1'b0;
            end else if (out_free) begin
                if (skid_valid_q) begin
                    out_valid_q <= 1'b1;
                    out_q       <= skid_q;
                end else begin
                    out_valid_q <= accept;
                    if (accept) out_q <= dec;
                end
            end
            if (accept && (skid_valid_q || !out_free)) skid_q <= dec;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_kind      = out_q.kind;
    assign bus.out_reg_a     = out_q.reg_a;
    assign bus.out_reg_b     = out_q.reg_b;
    assign bus.out_func      = out_q.func;
    assign bus.out_immd      = out_q.immd;
    assign bus.out_is_branch = out_q.is_branch;
    assign bus.out_relative  = out_q.relative;
    assign bus.out_pc        = out_q.pc;
endmodule

// File: tb/tb_insn_decode_stage.sv
// Bench for insn_decode_stage: directed ISA vectors and randomized words, with a
// scoreboard queue filled on acceptance and drained by a monitor on output transfers.
import insn_decode_stage_pkg::*;

module tb_insn_decode_stage;
    localparam int REC_W = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic rdy_mode = 1'b0;
    logic rdy_force = 1'b1;
    logic [REC_W-1:0] exp_q[$];

    insn_decode_stage_if bus ();

    insn_decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [REC_W-1:0] mk(input logic [2:0] kind, input logic [3:0] ra,
            input logic [3:0] rb, input logic [4:0] fn, input logic [15:0] imm,
            input logic br, input logic rel, input logic [15:0] pc);
        return {kind, ra, rb, fn, imm, br, rel, pc};
    endfunction

    // Reference decode straight from the ISA rules, using integer arithmetic on the word value.
    function automatic logic [REC_W-1:0] ref_decode(input logic [15:0] insn, input logic [15:0] pc);
        int v;
        int imm;
        int fn;
        v = int'(insn);
        if (v >= 'h8000)
            return mk(KIND_SET, 4'((v / 2048) % 16), 4'd0, 5'd0, 16'(v % 2048), 1'b0, 1'b0, pc);
        if (v >= 'h4000) begin
            imm = v % 4096;
            if (v % 8192 >= 4096) begin
                if (imm >= 2048) imm = imm - 4096;
                return mk(KIND_BRJ, 4'd0, 4'd0, 5'd0, 16'(imm), v >= 'h6000, 1'b1, pc);
            end
            return mk(KIND_BRJ, 4'd0, 4'd0, 5'd0, 16'(imm), v >= 'h6000, 1'b0, pc);
        end
        if (v >= 'h2000) begin
            fn = v % 32;
            if (fn >= NUM_FUNCS_DEF) return mk(KIND_ILL, 4'd0, 4'd0, 5'd0, 16'd0, 1'b0, 1'b0, pc);
            return mk(KIND_OP, 4'((v / 512) % 16), 4'((v / 32) % 16), 5'(fn), 16'd0, 1'b0, 1'b0, pc);
        end
        if (v == HLT_INSN) return mk(KIND_HLT, 4'd0, 4'd0, 5'd0, 16'd0, 1'b0, 1'b0, pc);
        if (v == NOP_INSN) return mk(KIND_NOP, 4'd0, 4'd0, 5'd0, 16'd0, 1'b0, 1'b0, pc);
        return mk(KIND_ILL, 4'd0, 4'd0, 5'd0, 16'd0, 1'b0, 1'b0, pc);
    endfunction

    function automatic logic [REC_W-1:0] dut_rec();
        return {bus.out_kind, bus.out_reg_a, bus.out_reg_b, bus.out_func, bus.out_immd,
                bus.out_is_branch, bus.out_relative, bus.out_pc};
    endfunction

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic check_rec(input string name, input logic [REC_W-1:0] got, input logic [REC_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic rdy_driver();
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    endtask

    task automatic monitor();
        logic             prev_stall = 1'b0;
        logic             prev_flush = 1'b0;
        logic [REC_W-1:0] prev_rec = '0;
        logic [REC_W-1:0] cur;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            cur = dut_rec();
            if (prev_stall && !prev_flush) begin
                check1("hold_valid", bus.out_valid, 1'b1);
                check_rec("hold_data", cur, prev_rec);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output got=%h exp=none t=%0t", cur, $time);
                end else begin
                    check_rec("out_entry", cur, exp_q.pop_front());
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_flush = bus.flush;
            prev_rec   = cur;
        end
    endtask

    // Entered and left at posedge+1; presents one word until it is taken.
    task automatic send_exp(input logic [15:0] insn, input logic [15:0] pc, input logic [REC_W-1:0] e);
        int budget = 300;
        bus.in_valid = 1'b1;
        bus.in_insn  = insn;
        bus.in_pc    = pc;
        while (!bus.in_ready && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (budget == 0) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout got=in_ready_low exp=accept insn=%h", insn);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] insn, input logic [15:0] pc);
        send_exp(insn, pc, ref_decode(insn, pc));
    endtask

    task automatic wait_drain();
        int budget = 300;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d_pending exp=0", exp_q.size());
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] w;
        int unsigned r;
        bus.in_valid  = 1'b0;
        bus.in_insn   = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.resume    = 1'b0;
        bus.out_ready = 1'b1;
        fork
            rdy_driver();
            monitor();
        join_none

        #1 rst_n = 1'b0;
        #1;
        check1("rst_out_valid", bus.out_valid, 1'b0);
        check1("rst_in_ready", bus.in_ready, 1'b0);
        check1("rst_halted", bus.halted, 1'b0);
        check_rec("rst_data", dut_rec(), '0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        check1("in_ready_after_rst", bus.in_ready, 1'b1);

        // Directed ISA vectors with hand-derived expectations.
        send_exp(16'h8ABC, 16'h0010, mk(KIND_SET, 4'd1, 4'd0, 5'd0, 16'h02BC, 1'b0, 1'b0, 16'h0010));
        send_exp(16'h5FFE, 16'h0012, mk(KIND_BRJ, 4'd0, 4'd0, 5'd0, 16'hFFFE, 1'b0, 1'b1, 16'h0012));
        send_exp(16'h7005, 16'h0014, mk(KIND_BRJ, 4'd0, 4'd0, 5'd0, 16'h0005, 1'b1, 1'b1, 16'h0014));
        send_exp(16'h4FFE, 16'h0016, mk(KIND_BRJ, 4'd0, 4'd0, 5'd0, 16'h0FFE, 1'b0, 1'b0, 16'h0016));
        send_exp(16'h2A21, 16'h0018, mk(KIND_OP, 4'd5, 4'd1, 5'h01, 16'h0000, 1'b0, 1'b0, 16'h0018));
        send_exp(16'h2011, 16'h001A, mk(KIND_OP, 4'd0, 4'd0, 5'h11, 16'h0000, 1'b0, 1'b0, 16'h001A));
        send_exp(16'h2012, 16'h001C, mk(KIND_ILL, 4'd0, 4'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 16'h001C));
        send_exp(16'h0002, 16'h001E, mk(KIND_ILL, 4'd0, 4'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 16'h001E));
        send_exp(16'h0001, 16'h0020, mk(KIND_NOP, 4'd0, 4'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 16'h0020));
        wait_drain();

        // Backpressure: four words while the output is stalled.
        rdy_force = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(16'(16'hC000 + i * 16'h0111), 16'(16'h0100 + i));
            end
            begin
                repeat (3) @(posedge clk);
                #3;
                check1("bp_in_ready_dropped", bus.in_ready, 1'b0);
                checks++;
                if (exp_q.size() != 2) begin
                    failures++;
                    $display("FAIL bp_accepts got=%0d exp=2", exp_q.size());
                end
                rdy_force = 1'b1;
            end
        join
        wait_drain();

        // Halt, blocked word, then resume lets it through.
        send(16'h0000, 16'h0200);
        check1("halted_set", bus.halted, 1'b1);
        check1("halt_in_ready", bus.in_ready, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_insn  = 16'h8001;
        bus.in_pc    = 16'h0202;
        repeat (3) begin
            step();
            check1("halt_hold_in_ready", bus.in_ready, 1'b0);
            check1("halt_hold_halted", bus.halted, 1'b1);
        end
        wait_drain();
        bus.resume = 1'b1;
        step();
        bus.resume = 1'b0;
        check1("resume_halted", bus.halted, 1'b0);
        check1("resume_in_ready", bus.in_ready, 1'b1);
        send_exp(16'h8001, 16'h0202, mk(KIND_SET, 4'd0, 4'd0, 5'd0, 16'h0001, 1'b0, 1'b0, 16'h0202));
        wait_drain();

        // Resume in RUN has no effect; flush together with resume leaves HALTED.
        bus.resume = 1'b1;
        step();
        bus.resume = 1'b0;
        check1("resume_in_run", bus.halted, 1'b0);
        send(16'h0000, 16'h0300);
        bus.flush  = 1'b1;
        bus.resume = 1'b1;
        step();
        bus.flush  = 1'b0;
        bus.resume = 1'b0;
        check1("flush_resume_halted", bus.halted, 1'b0);
        check1("flush_resume_valid", bus.out_valid, 1'b0);
        check1("flush_resume_ready", bus.in_ready, 1'b1);
        exp_q.delete();

        // Flush with both entries occupied; the word offered alongside is dropped.
        rdy_force = 1'b0;
        step();
        send(16'h9111, 16'h0400);
        send(16'h9222, 16'h0402);
        check1("full_in_ready", bus.in_ready, 1'b0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        exp_q.delete();
        check1("flush_out_valid", bus.out_valid, 1'b0);
        check1("flush_in_ready", bus.in_ready, 1'b1);
        send(16'h9333, 16'h0404);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_insn  = 16'hA444;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        check1("flush_drop_valid", bus.out_valid, 1'b0);
        rdy_force = 1'b1;
        repeat (3) step();

        // Asynchronous reset in the middle of a stalled stream.
        rdy_force = 1'b0;
        step();
        send(16'hB555, 16'h0500);
        send(16'h2A21, 16'h0502);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check1("midrst_out_valid", bus.out_valid, 1'b0);
        check1("midrst_in_ready", bus.in_ready, 1'b0);
        check_rec("midrst_data", dut_rec(), '0);
        rdy_force = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        check1("midrst_release_ready", bus.in_ready, 1'b1);

        // Randomized words against the reference model with random backpressure.
        rdy_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            if (r < 5)       w = {1'b1, 15'($urandom)};
            else if (r < 9)  w = {2'b01, 14'($urandom)};
            else if (r < 15) w = {3'b001, 13'($urandom)};
            else if (r < 19) w = 16'($urandom_range(1, 3));
            else             w = 16'h0000;
            send(w, 16'($urandom));
            if (w == 16'h0000) begin
                check1("rand_halted", bus.halted, 1'b1);
                check1("rand_halt_ready", bus.in_ready, 1'b0);
                repeat (2) step();
                bus.resume = 1'b1;
                step();
                bus.resume = 1'b0;
                check1("rand_resumed", bus.halted, 1'b0);
            end
            if ($urandom_range(0, 3) == 0) step();
        end
        rdy_mode = 1'b0;
        rdy_force = 1'b1;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
